teclado_pin: RTL and testbench

- Keypad front end that drives the gate controller's PIN interface (Pin[7:0] plus the enterPin strobe).
- Collects two BCD digit keystrokes from a keypad scanner and packs them into an 8-bit PIN, first digit in the high nibble. The code "1","0" therefore yields 8'h10.
- On the enter key, presents Pin and issues a single-cycle enterPin pulse.
- Handles clear, invalid-key, short-entry and inactivity-timeout cases. Accepts entry only while a vehicle is present or the gate is blocked.

---
 rtl/teclado_pin.sv | 111 +++++++++++
 tb/tb_teclado_pin.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/teclado_pin.sv
// Keypad front end for the gate controller: collects two BCD digits, packs
// them into an 8-bit PIN and strobes enterPin on the enter key.
module teclado_pin #(
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Tecla,
  input  logic       TeclaValida,
  input  logic       Vehiculo,
  input  logic       Bloqueo,
  output logic [7:0] Pin,
  output logic       enterPin,
  output logic [1:0] Digitos,
  output logic       ErrorTecla
);

  typedef enum logic [1:0] {VACIO = 2'd0, UNO = 2'd1, LISTO = 2'd2} estado_t;

  localparam logic [TIMEOUT_W-1:0] CUENTA_FIN = TIMEOUT_W'(TIMEOUT - 1);

  estado_t              estado;
  logic [7:0]           buffer;
  logic [TIMEOUT_W-1:0] cuenta;
  logic                 tecla_valida_q;

  logic evento;
  logic hab;
  logic es_digito;
  logic es_clear;
  logic es_enter;
  logic expira;

  // One event per key press: rising edge of the scanner's key-down level
  assign evento    = TeclaValida & ~tecla_valida_q;
  assign hab       = Vehiculo | Bloqueo;
  assign es_digito = (Tecla <= 4'd9);
  assign es_clear  = (Tecla == 4'hA);
  assign es_enter  = (Tecla == 4'hB);
  assign expira    = (cuenta == CUENTA_FIN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado         <= VACIO;
      buffer         <= 8'h00;
      cuenta         <= '0;
      tecla_valida_q <= 1'b0;
      Pin            <= 8'h00;
      enterPin       <= 1'b0;
      Digitos        <= 2'd0;
      ErrorTecla     <= 1'b0;
    end else begin
      tecla_valida_q <= TeclaValida;
      enterPin       <= 1'b0;
      ErrorTecla     <= 1'b0;

      if (!hab) begin
        // No vehicle and gate not blocked: drop any partial entry silently
        estado  <= VACIO;
        buffer  <= 8'h00;
        cuenta  <= '0;
        Digitos <= 2'd0;
      end else if (evento) begin
        cuenta <= '0;
        if (es_clear) begin
          estado  <= VACIO;
          buffer  <= 8'h00;
          Digitos <= 2'd0;
        end else if (es_enter) begin
          if (estado == LISTO) begin
            Pin      <= buffer;
            enterPin <= 1'b1;
          end else begin
            ErrorTecla <= 1'b1;
          end
          estado  <= VACIO;
          buffer  <= 8'h00;
          Digitos <= 2'd0;
        end else if (es_digito) begin
          case (estado)
            VACIO: begin
              buffer[7:4] <= Tecla;
              estado      <= UNO;
              Digitos     <= 2'd1;
            end
            UNO: begin
              buffer[3:0] <= Tecla;
              estado      <= LISTO;
              Digitos     <= 2'd2;
            end
            default: ErrorTecla <= 1'b1;
          endcase
        end else begin
          ErrorTecla <= 1'b1;
        end
      end else if (estado == VACIO) begin
        cuenta <= '0;
      end else if (expira) begin
        // Inactivity: discard the entry without flagging an error
        estado  <= VACIO;
        buffer  <= 8'h00;
        cuenta  <= '0;
        Digitos <= 2'd0;
      end else begin
        cuenta <= cuenta + TIMEOUT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_teclado_pin.sv
// Directed bench for teclado_pin with a short inactivity timeout.
module tb_teclado_pin;

  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned TIMEOUT_W = 4;

  logic       Clk;
  logic       Reset;
  logic [3:0] Tecla;
  logic       TeclaValida;
  logic       Vehiculo;
  logic       Bloqueo;
  logic [7:0] Pin;
  logic       enterPin;
  logic [1:0] Digitos;
  logic       ErrorTecla;

  int vectors     = 0;
  int miscompares = 0;
  int n_enter     = 0;
  int n_err       = 0;
  logic [7:0] pin_last = 8'h00;
  logic       first_en = 1'b0;

  teclado_pin #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Tecla(Tecla), .TeclaValida(TeclaValida),
    .Vehiculo(Vehiculo), .Bloqueo(Bloqueo), .Pin(Pin), .enterPin(enterPin),
    .Digitos(Digitos), .ErrorTecla(ErrorTecla)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and tally output pulses seen after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
    n_enter += int'(enterPin);
    n_err   += int'(ErrorTecla);
    if (enterPin) pin_last = Pin;
  endtask

  task automatic clr_counts();
    n_enter = 0;
    n_err   = 0;
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    Tecla       = k;
    TeclaValida = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (i == 0) first_en = enterPin;
    end
    TeclaValida = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic key(input logic [3:0] k);
    press(k, 3, 2);
  endtask

  initial begin
    Reset = 1'b1; Tecla = 4'h0; TeclaValida = 1'b0; Vehiculo = 1'b0; Bloqueo = 1'b0;
    tick(); tick();
    check("rst_pin", 32'(Pin), 32'h00);
    check("rst_enter", 32'(enterPin), 32'd0);
    check("rst_digitos", 32'(Digitos), 32'd0);
    check("rst_error", 32'(ErrorTecla), 32'd0);
    Reset = 1'b0;
    tick();

    // Basic 1,0,enter
    Vehiculo = 1'b1; clr_counts();
    key(4'h1); check("t1_dig1", 32'(Digitos), 32'd1);
    key(4'h0); check("t1_dig2", 32'(Digitos), 32'd2);
    key(4'hB);
    check("t1_latency", 32'(first_en), 32'd1);
    check("t1_n_enter", 32'(n_enter), 32'd1);
    check("t1_pin", 32'(pin_last), 32'h10);
    check("t1_dig0", 32'(Digitos), 32'd0);
    check("t1_n_err", 32'(n_err), 32'd0);

    // Short entry, then digit overflow rejected
    clr_counts();
    key(4'h3); key(4'hB);
    check("t2_short_err", 32'(n_err), 32'd1);
    check("t2_short_enter", 32'(n_enter), 32'd0);
    check("t2_short_dig", 32'(Digitos), 32'd0);
    clr_counts();
    key(4'h7); key(4'h4); key(4'h9);
    check("t2_over_err", 32'(n_err), 32'd1);
    check("t2_over_dig", 32'(Digitos), 32'd2);
    key(4'hB);
    check("t2_n_enter", 32'(n_enter), 32'd1);
    check("t2_pin", 32'(Pin), 32'h74);

    // Disabled entry, then blocked-gate entry
    Vehiculo = 1'b0; Bloqueo = 1'b0; clr_counts();
    key(4'h1); key(4'h0); key(4'hB);
    check("t3_dis_enter", 32'(n_enter), 32'd0);
    check("t3_dis_err", 32'(n_err), 32'd0);
    check("t3_dis_pin", 32'(Pin), 32'h74);
    check("t3_dis_dig", 32'(Digitos), 32'd0);
    Bloqueo = 1'b1; clr_counts();
    key(4'h1); key(4'h0); key(4'hB);
    check("t3_blk_enter", 32'(n_enter), 32'd1);
    check("t3_blk_pin", 32'(Pin), 32'h10);

    // Timeout: event edge E1, expiry decision at edge E1+8
    clr_counts();
    key(4'h5);
    tick(); tick(); tick();
    check("t4_before_expiry", 32'(Digitos), 32'd1);
    tick();
    check("t4_after_expiry", 32'(Digitos), 32'd0);
    check("t4_expiry_err", 32'(n_err), 32'd0);
    key(4'h2); key(4'hB);
    check("t4_short_err", 32'(n_err), 32'd1);
    check("t4_enter", 32'(n_enter), 32'd0);

    // Clear, invalid key, then 0,0,enter
    clr_counts();
    key(4'h1); key(4'hA);
    check("t5_clear_dig", 32'(Digitos), 32'd0);
    check("t5_clear_err", 32'(n_err), 32'd0);
    key(4'hE);
    check("t5_invalid_err", 32'(n_err), 32'd1);
    key(4'h0); key(4'h0); key(4'hB);
    check("t5_zero_enter", 32'(n_enter), 32'd1);
    check("t5_zero_pin", 32'(Pin), 32'h00);

    // Held key: one event only; no further events, so the timeout fires
    clr_counts();
    Tecla = 4'h1; TeclaValida = 1'b1;
    tick(); tick(); tick();
    check("t5_hold_dig", 32'(Digitos), 32'd1);
    for (int i = 0; i < 17; i++) tick();
    check("t5_hold_timeout", 32'(Digitos), 32'd0);
    check("t5_hold_err", 32'(n_err), 32'd0);
    TeclaValida = 1'b0; tick(); tick();

    // Reset mid-entry
    Bloqueo = 1'b0; Vehiculo = 1'b1;
    key(4'h3); key(4'h5); key(4'hB);
    check("t6_pre_pin", 32'(Pin), 32'h35);
    clr_counts();
    key(4'h1); key(4'h0);
    Reset = 1'b1; tick(); Reset = 1'b0;
    key(4'hB);
    check("t6_rst_enter", 32'(n_enter), 32'd0);
    check("t6_rst_dig", 32'(Digitos), 32'd0);
    check("t6_rst_pin", 32'(Pin), 32'h00);

    // Enable drops in the same cycle as the enter event
    clr_counts();
    key(4'h1); key(4'h0);
    Vehiculo = 1'b0; Bloqueo = 1'b0; Tecla = 4'hB; TeclaValida = 1'b1;
    tick();
    check("t6_hab_enter_now", 32'(enterPin), 32'd0);
    TeclaValida = 1'b0; tick(); tick();
    check("t6_hab_n_enter", 32'(n_enter), 32'd0);
    check("t6_hab_pin", 32'(Pin), 32'h00);
    check("t6_hab_dig", 32'(Digitos), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
